mips_muldiv: RTL and testbench
==============================

MIPS_MULDIV -- requirements
Module: mips_muldiv

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the operand and HI/LO width; legal values are even and at least 4.
REQ-002 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 start  input  1  SHALL request an operation; it is sampled on each rising edge.
REQ-005 op  input  3  SHALL select the operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 are no-ops.
REQ-006 a  input  WIDTH  SHALL carry the multiplicand, dividend, or MTHI/MTLO source.
REQ-007 b  input  WIDTH  SHALL carry the multiplier or divisor.
REQ-008 busy  output  1  SHALL be high while an iterative operation is in progress.
REQ-009 done  output  1  SHALL be a one-cycle completion pulse.
REQ-010 hi  output  WIDTH  SHALL be the architectural HI register.
REQ-011 lo  output  WIDTH  SHALL be the architectural LO register.

Function
REQ-012 The FSM SHALL have three states: IDLE, CALC and DONE; busy = (state==CALC) and done = (state==DONE).
REQ-013 start SHALL be accepted only in IDLE or DONE; while in CALC it SHALL be ignored, with no queueing.
REQ-014 An accepted MULT/MULTU/DIV/DIVU SHALL:
- latch a, b and op;
- enter CALC with a counter at 0;
- process one bit per cycle for exactly WIDTH cycles;
- enter DONE on the WIDTH-th edge after acceptance, writing hi/lo on that edge.
REQ-015 DONE SHALL last one cycle, then go to IDLE; a start accepted in DONE goes directly to CALC (back-to-back).
REQ-016 hi/lo SHALL hold their previous values throughout CALC; partial results SHALL stay internal.
REQ-017 MULT/MULTU SHALL use shift-add and produce the 2*WIDTH-bit product: {hi,lo}.
REQ-018 DIV/DIVU SHALL use restoring division: lo = quotient, hi = remainder.
REQ-019 Signed ops SHALL work on magnitudes and sign-correct at completion.
- Quotient truncates toward zero.
- Remainder takes the sign of the dividend.
REQ-020 Signed most-negative / -1 SHALL give lo = most-negative value and hi = 0.
REQ-021 A divisor of 0 SHALL still take WIDTH cycles and give lo = all-ones and hi = a.
REQ-022 An accepted MTHI/MTLO SHALL write a to hi/lo on the accepting edge, with no busy and no done; the FSM goes to, or stays in, IDLE.
REQ-023 op 110/111 with start SHALL change no state.

Reset
REQ-024 reset_n low SHALL immediately force:
- state = IDLE, busy = 0, done = 0;
- hi = 0, lo = 0;
- counter and internal registers = 0.
REQ-025 Reset asserted mid-CALC SHALL abort the operation with no result write; the first edge after release SHALL accept a new start.

Configuration
REQ-026 With macro MIPS_MULDIV_DIV_EN defined, the divider datapath and DIV/DIVU SHALL be implemented as in REQ-018 to REQ-021.
REQ-027 Without MIPS_MULDIV_DIV_EN:
- no divider logic SHALL be synthesised;
- an accepted DIV/DIVU SHALL skip CALC, go straight to DONE (done one cycle later) and leave hi/lo unchanged;
- multiply and MTHI/MTLO SHALL be unaffected.

Verification (WIDTH=32 unless stated; latency counted from the accepting edge)
REQ-028 MULTU a=FFFFFFFF b=FFFFFFFF -> busy for 32 cycles, then done for 1 cycle with hi=FFFFFFFE, lo=00000001.
REQ-029 MULT a=FFFFFFFD (-3) b=00000007 -> hi=FFFFFFFF, lo=FFFFFFEB; then DIV a=FFFFFFF9 (-7) b=2 -> lo=FFFFFFFD, hi=FFFFFFFF.
REQ-030 DIVU a=00000064 b=0 -> after 32 cycles lo=FFFFFFFF, hi=00000064; DIV a=80000000 b=FFFFFFFF -> lo=80000000, hi=0.
REQ-031 Start MULT, pulse start with DIVU at cycle 5 -> ignored, MULT result only; reset_n low at cycle 10 of a new MULT -> busy=0, hi=lo=0, and the next start is accepted.
REQ-032 MTHI a=12345678 then MTLO a=9ABCDEF0 -> hi/lo updated on each accepting edge, done never asserted; back-to-back MULTU issued in the DONE cycle -> second done exactly 32 cycles after the first.
REQ-033 WIDTH=8, MULTU a=FF b=FF -> done after 8 cycles, hi=FE, lo=01; build without MIPS_MULDIV_DIV_EN, DIVU -> done next cycle, hi/lo unchanged.

Source files
------------

// File: rtl/mips_muldiv.sv
// MIPS HI/LO unit: iterative shift-add multiply and restoring divide, one bit per cycle.
// Optional feature macro: MIPS_MULDIV_DIV_EN builds the divider; otherwise DIV/DIVU finish at once and leave HI/LO unchanged.
module mips_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int unsigned   CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opnd, acc_hi, acc_lo;
  logic             neg_a, neg_b;

  logic             accept, is_mul, is_div, sgn, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag, step_hi, step_lo, res_hi, res_lo;
  logic [WIDTH:0]   mul_sum;
  logic [2*WIDTH-1:0] prod;
`ifdef MIPS_MULDIV_DIV_EN
  logic             div_q;
  logic [WIDTH:0]   shifted, trial;
  logic             fits;
  logic [WIDTH-1:0] quo, rem;
`endif

  always_comb begin
    accept = start && (state != CALC);
    is_mul = (op[2:1] == 2'b00);
    is_div = (op[2:1] == 2'b01);
    sgn    = ~op[0];
    a_neg  = sgn & a[WIDTH-1];
    b_neg  = sgn & b[WIDTH-1];
    a_mag  = a_neg ? -a : a;
    b_mag  = b_neg ? -b : b;

    state_n = IDLE;
    if (state == CALC) state_n = (cnt == LAST) ? DONE : CALC;
    if (accept) begin
      if (is_mul) state_n = CALC;
`ifdef MIPS_MULDIV_DIV_EN
      else if (is_div) state_n = CALC;
`else
      else if (is_div) state_n = DONE;
`endif
    end

    // acc_lo shifts the multiplier out while product bits shift in from the top
    mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    step_hi = mul_sum[WIDTH:1];
    step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    prod    = {step_hi, step_lo};
    if (neg_a ^ neg_b) prod = -prod;
    res_hi  = prod[2*WIDTH-1:WIDTH];
    res_lo  = prod[WIDTH-1:0];

`ifdef MIPS_MULDIV_DIV_EN
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    trial   = shifted - {1'b0, opnd};
    fits    = ~trial[WIDTH];
    rem     = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo     = {acc_lo[WIDTH-2:0], fits};
    if (div_q) begin
      step_hi = rem;
      step_lo = quo;
      // zero divisor: remainder already equals |a|, so sign fix-up restores a
      res_lo  = (opnd == '0) ? '1 : ((neg_a ^ neg_b) ? -quo : quo);
      res_hi  = neg_a ? -rem : rem;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      cnt    <= '0;
      opnd   <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      hi     <= '0;
      lo     <= '0;
`ifdef MIPS_MULDIV_DIV_EN
      div_q  <= 1'b0;
`endif
    end else begin
      state <= state_n;
      busy  <= (state_n == CALC);
      done  <= (state_n == DONE);
      if (accept) begin
        if (is_mul) begin
          cnt    <= '0;
          opnd   <= a_mag;
          acc_hi <= '0;
          acc_lo <= b_mag;
          neg_a  <= a_neg;
          neg_b  <= b_neg;
`ifdef MIPS_MULDIV_DIV_EN
          div_q  <= 1'b0;
`endif
        end
`ifdef MIPS_MULDIV_DIV_EN
        else if (is_div) begin
          cnt    <= '0;
          opnd   <= b_mag;
          acc_hi <= '0;
          acc_lo <= a_mag;
          neg_a  <= a_neg;
          neg_b  <= b_neg;
          div_q  <= 1'b1;
        end
`endif
        else if (op == 3'b100) hi <= a;
        else if (op == 3'b101) lo <= a;
      end else if (state == CALC) begin
        cnt    <= cnt + 1'b1;
        acc_hi <= step_hi;
        acc_lo <= step_lo;
        if (cnt == LAST) begin
          hi <= res_hi;
          lo <= res_lo;
        end
      end
    end
  end
endmodule

// File: tb/tb_mips_muldiv.sv
// Self-checking bench for mips_muldiv: directed corner cases plus randomized ops against an arithmetic model.
module tb_mips_muldiv;
  logic        clk = 1'b0;
  logic        reset_n, start;
  logic [2:0]  op;
  logic [31:0] a, b, hi, lo;
  logic        busy, done;
  logic        start8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, hi8, lo8;
  logic        busy8, done8;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;
  int          exp_lat;

  always #5 clk = ~clk;

  mips_muldiv dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  mips_muldiv #(.WIDTH(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );

  // Reference: architectural result from plain arithmetic; exp_lat = edges after accept until done (-1: no done)
  task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_lat = -1;
    case (o)
      3'b000: begin
        longint sp;
        sp = longint'($signed(x)) * longint'($signed(y));
        {exp_hi, exp_lo} = sp;
        exp_lat = 32;
      end
      3'b001: begin
        logic [63:0] up;
        up = {32'b0, x} * {32'b0, y};
        {exp_hi, exp_lo} = up;
        exp_lat = 32;
      end
      3'b010, 3'b011: begin
`ifdef MIPS_MULDIV_DIV_EN
        longint sx, sy;
        if (y == 32'd0) begin
          exp_lo = '1;
          exp_hi = x;
        end else if (o == 3'b010) begin
          sx = longint'($signed(x));
          sy = longint'($signed(y));
          exp_lo = 32'(sx / sy);
          exp_hi = 32'(sx % sy);
        end else begin
          exp_lo = x / y;
          exp_hi = x % y;
        end
        exp_lat = 32;
`else
        exp_lat = 0;
`endif
      end
      3'b100: exp_hi = x;
      3'b101: exp_lo = x;
      default: ;
    endcase
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input string tag, output logic was_done);
    int lat, nbusy;
    logic held;
    logic [31:0] ph, pl;
    @(negedge clk);
    was_done = done;
    ph = hi;
    pl = lo;
    start = 1'b1; op = o; a = x; b = y;
    model(o, x, y);
    @(posedge clk); #1;
    start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
    lat = 0; nbusy = 0; held = 1'b1;
    if (exp_lat < 0) begin
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL %s flags: busy=%b done=%b, required 0 0", tag, busy, done);
      end
    end else begin
      while (done !== 1'b1 && lat < 100) begin
        if (busy === 1'b1) nbusy++;
        if (hi !== ph || lo !== pl) held = 1'b0;
        @(posedge clk); #1;
        lat++;
      end
      checks++;
      if (lat != exp_lat) begin
        errors++;
        $display("FAIL %s latency: got %0d, required %0d", tag, lat, exp_lat);
      end
      checks++;
      if (nbusy != exp_lat || held !== 1'b1) begin
        errors++;
        $display("FAIL %s busy/hold: busy_cycles=%0d held=%b, required %0d 1", tag, nbusy, held, exp_lat);
      end
    end
    checks++;
    if (hi !== exp_hi || lo !== exp_lo) begin
      errors++;
      $display("FAIL %s hilo: got %h_%h, required %h_%h", tag, hi, lo, exp_hi, exp_lo);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    #1 reset_n = 1'b0;
    #2;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL reset32: busy=%b done=%b hi=%h lo=%h, required all zero", busy, done, hi, lo);
    end
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || hi8 !== 8'd0 || lo8 !== 8'd0) begin
      errors++;
      $display("FAIL reset8: busy=%b done=%b hi=%h lo=%h, required all zero", busy8, done8, hi8, lo8);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_mul();
    logic wd;
    do_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max", wd);
    checks++;
    if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
      errors++;
      $display("FAIL multu_max_const: got %h_%h, required fffffffe_00000001", hi, lo);
    end
    do_op(3'b000, 32'hFFFF_FFFD, 32'h0000_0007, "mult_neg", wd);
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin
      errors++;
      $display("FAIL mult_neg_const: got %h_%h, required ffffffff_ffffffeb", hi, lo);
    end
  endtask

  task automatic test_div();
    logic wd;
    do_op(3'b010, 32'hFFFF_FFF9, 32'h0000_0002, "div_neg", wd);
`ifdef MIPS_MULDIV_DIV_EN
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
      errors++;
      $display("FAIL div_neg_const: got %h_%h, required ffffffff_fffffffd", hi, lo);
    end
`endif
    do_op(3'b011, 32'h0000_0064, 32'h0000_0000, "divu_zero", wd);
    do_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", wd);
    do_op(3'b010, 32'hFFFF_FFF9, 32'h0000_0000, "div_zero_neg", wd);
    do_op(3'b010, 32'h0000_0007, 32'hFFFF_FFFE, "div_negdivisor", wd);
  endtask

  task automatic test_mt();
    logic wd;
    do_op(3'b100, 32'h1234_5678, 32'h0, "mthi", wd);
    do_op(3'b101, 32'h9ABC_DEF0, 32'h0, "mtlo", wd);
    checks++;
    if (hi !== 32'h1234_5678 || lo !== 32'h9ABC_DEF0) begin
      errors++;
      $display("FAIL mt_const: got %h_%h, required 12345678_9abcdef0", hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    logic wd;
    do_op(3'b001, $urandom, $urandom, "b2b_first", wd);
    do_op(3'b001, $urandom, $urandom, "b2b_second", wd);
    checks++;
    if (wd !== 1'b1) begin
      errors++;
      $display("FAIL b2b_issue_in_done: done=%b at issue, required 1", wd);
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    logic [31:0] x, y;
    x = $urandom; y = $urandom;
    @(negedge clk);
    start = 1'b1; op = 3'b000; a = x; b = y;
    model(3'b000, x, y);
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (lat == 5) begin
        @(negedge clk);
        start = 1'b1; op = 3'b011; a = 32'd100; b = 32'd0;
      end
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
    end
    checks++;
    if (lat != 32 || hi !== exp_hi || lo !== exp_lo) begin
      errors++;
      $display("FAIL ignore_start: lat=%0d hilo=%h_%h, required 32 %h_%h", lat, hi, lo, exp_hi, exp_lo);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL ignore_no_queue: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_nop();
    logic wd;
    do_op(3'b110, $urandom, $urandom, "nop110", wd);
    do_op(3'b111, $urandom, $urandom, "nop111", wd);
  endtask

  task automatic test_random();
    logic wd;
    for (int i = 0; i < 40; i++) begin
      do_op(3'($urandom_range(0, 7)), pick(), pick(), "random", wd);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    @(negedge clk);
    start = 1'b1; op = 3'b000; a = $urandom; b = $urandom;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h, required all zero", busy, done, hi, lo);
    end
    exp_hi = '0; exp_lo = '0;
    @(negedge clk);
    reset_n = 1'b1;
    start = 1'b1; op = 3'b001; a = 32'd5; b = 32'd6;
    model(3'b001, 32'd5, 32'd6);
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_accept: busy=%b, required 1", busy);
    end
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat != 32 || hi !== exp_hi || lo !== exp_lo) begin
      errors++;
      $display("FAIL reset_next_op: lat=%0d hilo=%h_%h, required 32 %h_%h", lat, hi, lo, exp_hi, exp_lo);
    end
  endtask

  task automatic test_width8();
    int lat, el;
    logic [7:0] eh, elo;
    @(negedge clk);
    start8 = 1'b1; op8 = 3'b001; a8 = 8'hFF; b8 = 8'hFF;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0;
    while (done8 !== 1'b1 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat != 8 || hi8 !== 8'hFE || lo8 !== 8'h01) begin
      errors++;
      $display("FAIL w8_multu: lat=%0d hilo=%h_%h, required 8 fe_01", lat, hi8, lo8);
    end
`ifdef MIPS_MULDIV_DIV_EN
    eh = 8'h02; elo = 8'h0E; el = 8;
`else
    eh = 8'hFE; elo = 8'h01; el = 0;
`endif
    @(negedge clk);
    start8 = 1'b1; op8 = 3'b011; a8 = 8'h64; b8 = 8'h07;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0;
    while (done8 !== 1'b1 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat != el || hi8 !== eh || lo8 !== elo) begin
      errors++;
      $display("FAIL w8_divu: lat=%0d hilo=%h_%h, required %0d %h_%h", lat, hi8, lo8, el, eh, elo);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_mt();
    test_back_to_back();
    test_ignore_start();
    test_nop();
    test_random();
    test_reset_mid();
    test_width8();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
